// File: rtl/seq_mult_pkg.sv
// Shared definitions for the digit-serial multiplier slice: the product
// collector state type and width helpers derived from P and MAX_WIDTH.
package seq_mult_pkg;

    // Collector FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } collect_state_e;

    // Width of the bit_size port (operand width in digits, with headroom
    // so that illegal values above MAX_WIDTH/P are representable).
    function automatic int bsz_width(input int max_w, input int p);
        return $clog2(max_w / p) + 2;
    endfunction

    // Number of product digits for a full-width product.
    function automatic int max_digits(input int max_w, input int p);
        return (2 * max_w) / p;
    endfunction

    // Width of the product digit counter.
    function automatic int cnt_width(input int max_w, input int p);
        return $clog2(max_digits(max_w, p)) + 1;
    endfunction

endpackage

// File: rtl/seq_sign_ext.sv
// Combinational sign extension of a product word: every bit above the
// runtime position msb_idx is replaced by the bit at msb_idx.
module seq_sign_ext #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_in,
    input  logic [IDX_W-1:0] msb_idx,
    output logic [WIDTH-1:0] word_out
);

    // Replicate the sign bit into all positions above msb_idx
    always_comb begin
        word_out = word_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (i > int'(msb_idx)) begin
                word_out[i] = word_in[msb_idx];
            end else begin
                word_out[i] = word_in[i];
            end
        end
    end

endmodule

// File: rtl/seq_product_collector.sv
// Receive side of the digit-serial multiplier: assembles LSB-first product
// digits into a full-width word, extends it and offers it over valid/ready.
// Build option: SEQ_COLLECT_SIGNEXT_EN selects two's-complement extension of
// the finished product; without it the upper bits stay zero.
module seq_product_collector
    import seq_mult_pkg::*;
#(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [bsz_width(MAX_WIDTH, P)-1:0]  bit_size,
    input  logic                                digit_valid,
    input  logic [P-1:0]                        digit,
    input  logic                                digit_last,
    output logic                                prod_valid,
    input  logic                                prod_ready,
    output logic [2*MAX_WIDTH-1:0]              prod,
    output logic                                busy,
    output logic                                err
);

    localparam int BSZ_W   = bsz_width(MAX_WIDTH, P);
    localparam int CNT_W   = cnt_width(MAX_WIDTH, P);
    localparam int PW      = 2 * MAX_WIDTH;
    localparam int IDX_W   = $clog2(PW);
    localparam int MAX_BSZ = MAX_WIDTH / P;

    collect_state_e     state_r;
    collect_state_e     state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [CNT_W-1:0]   last_idx_s;
    logic [BSZ_W-1:0]   bsz_r;
    logic [BSZ_W-1:0]   bsz_nxt_s;
    logic [PW-1:0]      prod_r;
    logic [PW-1:0]      prod_nxt_s;
    logic [PW-1:0]      prod_wr_s;
    logic [PW-1:0]      prod_ext_s;
    logic [IDX_W-1:0]   wr_base_s;
    logic               err_r;
    logic               err_nxt_s;
    logic               busy_r;
    logic               prod_valid_r;
    logic               bsz_legal_s;
    logic               final_digit_s;

    assign bsz_legal_s   = (bit_size != {BSZ_W{1'b0}}) && (bit_size <= BSZ_W'(MAX_BSZ));
    // Index of the last product digit: 2*bit_size - 1
    assign last_idx_s    = CNT_W'({bsz_r, 1'b0}) - CNT_W'(1);
    assign final_digit_s = (cnt_r == last_idx_s);
    assign wr_base_s     = IDX_W'(int'(cnt_r) * P);

    // Product register with the incoming digit merged at the counter position
    always_comb begin
        prod_wr_s = prod_r;
        prod_wr_s[wr_base_s +: P] = digit;
    end

`ifdef SEQ_COLLECT_SIGNEXT_EN
    logic [IDX_W-1:0] msb_idx_s;

    // Sign bit of the 2W-bit product sits at 2*P*bit_size - 1
    assign msb_idx_s = IDX_W'(int'(bsz_r) * 2 * P - 1);

    seq_sign_ext #(
        .WIDTH (PW),
        .IDX_W (IDX_W)
    ) u_sign_ext (
        .word_in  (prod_wr_s),
        .msb_idx  (msb_idx_s),
        .word_out (prod_ext_s)
    );
`else
    // Upper bits were cleared at start and never written, so they are zero
    assign prod_ext_s = prod_wr_s;
`endif

    // Next-state, counter, product and error-flag logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bsz_nxt_s   = bsz_r;
        prod_nxt_s  = prod_r;
        err_nxt_s   = err_r;
        if (start) begin
            prod_nxt_s = {PW{1'b0}};
            cnt_nxt_s  = {CNT_W{1'b0}};
            if (bsz_legal_s) begin
                bsz_nxt_s   = bit_size;
                err_nxt_s   = 1'b0;
                state_nxt_s = ST_COLLECT;
            end else begin
                err_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_COLLECT: begin
                    if (digit_valid) begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                        if (final_digit_s) begin
                            prod_nxt_s  = prod_ext_s;
                            state_nxt_s = ST_HOLD;
                            if (!digit_last) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                err_nxt_s = err_r;
                            end
                        end else begin
                            prod_nxt_s = prod_wr_s;
                            if (digit_last) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                err_nxt_s = err_r;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end
                ST_HOLD: begin
                    // A digit arriving here is an overrun: drop it, flag it
                    if (digit_valid) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                    if (prod_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            bsz_r        <= {BSZ_W{1'b0}};
            prod_r       <= {PW{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            prod_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            bsz_r        <= bsz_nxt_s;
            prod_r       <= prod_nxt_s;
            err_r        <= err_nxt_s;
            busy_r       <= (state_nxt_s == ST_COLLECT);
            prod_valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    assign prod       = prod_r;
    assign prod_valid = prod_valid_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule
